ppu_oam: RTL and testbench

PPU_OAM -- requirements
Module: ppu_oam

---
 rtl/ppu_oam.sv | 47 ++++
 tb/tb_ppu_oam.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ppu_oam.sv
// Sprite attribute memory: 64 entries x 4 bytes, synchronous write, combinational read.
// Reset clears every byte and wins over a write presented on the same edge.
module ppu_oam (
  input  logic       clk,
  input  logic       rst,
  input  logic       oam_en,
  input  logic       oam_rw,
  input  logic [5:0] spr_select,
  input  logic [1:0] byte_select,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;

  // CPU linear OAM address is sprite index over byte-within-entry
  assign addr  = {spr_select, byte_select};
  assign wr_en = oam_en & ~oam_rw;
  assign rd_en = oam_en &  oam_rw;

  // Storage: full clear on reset, otherwise single-byte write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= data_in;
    end
  end

  // Read port drives zero whenever no read is presented
  always_comb begin
    data_out = '0;
    if (rd_en) begin
      data_out = mem[addr];
    end
  end

endmodule

// File: tb/tb_ppu_oam.sv
// Self-checking bench for ppu_oam: reference byte model plus an expected-value queue
// filled as each access is driven and drained when data_out is sampled.
module tb_ppu_oam;

  logic       clk;
  logic       rst;
  logic       oam_en;
  logic       oam_rw;
  logic [5:0] spr_select;
  logic [1:0] byte_select;
  logic [7:0] data_in;
  logic [7:0] data_out;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_fails;

  ppu_oam dut (
    .clk         (clk),
    .rst         (rst),
    .oam_en      (oam_en),
    .oam_rw      (oam_rw),
    .spr_select  (spr_select),
    .byte_select (byte_select),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp_v);
    end
  endtask

  task automatic set_addr(input logic [7:0] a);
    spr_select  = a[7:2];
    byte_select = a[1:0];
  endtask

  // Pop one expectation at the falling edge and compare against data_out
  task automatic sample(input string tag);
    logic [7:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: scoreboard empty, got 0x%02h expected an entry", tag, data_out);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, data_out, e);
    end
  endtask

  // Advance past the rising edge and apply its effect to the model
  task automatic clock_edge();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
    end else if (oam_en && !oam_rw) begin
      model[{spr_select, byte_select}] = data_in;
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic with_rst);
    rst     = with_rst;
    oam_en  = 1'b1;
    oam_rw  = 1'b0;
    set_addr(a);
    data_in = d;
    exp_q.push_back(8'h00);
    sample("wr_dout_zero");
    clock_edge();
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    rst     = 1'b0;
    oam_en  = 1'b1;
    oam_rw  = 1'b1;
    set_addr(a);
    data_in = 8'($urandom);
    exp_q.push_back(model[a]);
    sample(tag);
    clock_edge();
  endtask

  task automatic idle(input logic [7:0] a, input logic [7:0] d, input logic with_rst);
    rst     = with_rst;
    oam_en  = 1'b0;
    oam_rw  = 1'($urandom);
    set_addr(a);
    data_in = d;
    exp_q.push_back(8'h00);
    sample("idle_dout_zero");
    clock_edge();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 256; i++) model[i] = 8'hxx;
    rst = 1'b1; oam_en = 1'b0; oam_rw = 1'b1; data_in = 8'h00;
    set_addr(8'h00);

    // Power-up clear
    clock_edge();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) rd(8'(i), "powerup_clear");

    // Fill and readback
    for (int i = 0; i < 256; i++) wr(8'(i), 8'(i), 1'b0);
    for (int i = 0; i < 256; i++) begin
      rd(8'(i), "fill_readback");
      check_eq("fill_value_is_addr", model[i], 8'(i));
    end

    // Ignored accesses
    wr(8'h13, 8'hA5, 1'b0);
    idle(8'h13, 8'h5A, 1'b0);
    rst = 1'b0; oam_en = 1'b1; oam_rw = 1'b1; set_addr(8'h13); data_in = 8'h5A;
    exp_q.push_back(8'hA5);
    sample("read_with_data_in");
    clock_edge();
    rd(8'h13, "ignored_keeps_a5");

    // Sprite/byte mapping: sprite 15 byte 3 is address 0x3F
    rst = 1'b0; oam_en = 1'b1; oam_rw = 1'b0;
    spr_select = 6'd15; byte_select = 2'd3; data_in = 8'h3C;
    exp_q.push_back(8'h00);
    sample("map_wr_dout_zero");
    clock_edge();
    rd(8'h3F, "map_3f");
    rd(8'h3E, "map_3e_unchanged");
    rd(8'h7F, "map_7f_unchanged");
    check_eq("map_3e_model", model[8'h3E], 8'h3E);

    // Back-to-back accesses to one address, plus last-write-wins
    wr(8'h40, 8'h11, 1'b0);
    rd(8'h40, "b2b_first");
    wr(8'h40, 8'h22, 1'b0);
    rd(8'h40, "b2b_second");
    wr(8'h41, 8'h01, 1'b0);
    wr(8'h41, 8'h02, 1'b0);
    wr(8'h41, 8'h03, 1'b0);
    rd(8'h41, "last_write_wins");

    // Random mix of reads, writes and idles
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(2))
        0:       wr(8'($urandom), 8'($urandom), 1'b0);
        1:       rd(8'($urandom), "random_rd");
        default: idle(8'($urandom), 8'($urandom), 1'b0);
      endcase
    end

    // Refill, then reset coincides with a write of 0xFF to 0x80
    for (int i = 0; i < 256; i++) wr(8'(i), 8'(i), 1'b0);
    wr(8'h80, 8'hFF, 1'b1);
    // Reads during a held reset return zero after the clearing edge
    rst = 1'b1; oam_en = 1'b1; oam_rw = 1'b1; set_addr(8'h80);
    exp_q.push_back(8'h00);
    sample("read_during_rst");
    clock_edge();
    idle(8'h80, 8'hFF, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) rd(8'(i), "mid_reset_clear");
    check_eq("mid_reset_model_80", model[8'h80], 8'h00);

    // Accesses resume right after reset
    wr(8'h80, 8'h5C, 1'b0);
    rd(8'h80, "post_reset_write");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
